// File: rtl/mc_control_unit.sv
// Multi-cycle control FSM for the 16-bit TSC datapath: sequences IF/ID/EX/WB/MEM phases,
// drives the Moore control vector, waits on memory handshakes and counts retired instructions.
module mc_control_unit #(
  parameter int WORD_SIZE       = 16,
  parameter bit HALT_ON_UNKNOWN = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [3:0]           opcode,
  input  logic [5:0]           func,
  input  logic                 mem_ready,
  output logic [15:0]          signal,
  output logic [3:0]           state,
  output logic [WORD_SIZE-1:0] num_inst,
  output logic                 halted
);

  typedef enum logic [3:0] {
    S_IF   = 4'd0,
    S_ID   = 4'd1,
    S_EX   = 4'd2,
    S_WB   = 4'd3,
    S_MADR = 4'd4,
    S_MEM  = 4'd5,
    S_MWB  = 4'd6,
    S_BR1  = 4'd7,
    S_BR2  = 4'd8,
    S_JMP  = 4'd9,
    S_JAL  = 4'd10,
    S_JR   = 4'd11,
    S_HALT = 4'd15
  } state_t;

  state_t cur, nxt;
  state_t unknown_dest;
  logic   retire;

  assign unknown_dest = HALT_ON_UNKNOWN ? S_HALT : S_IF;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cur      <= S_IF;
      num_inst <= '0;
    end else begin
      cur <= nxt;
      if (retire) num_inst <= num_inst + WORD_SIZE'(1);
    end
  end

  always_comb begin
    nxt    = S_HALT;
    signal = 16'h0000;
    case (cur)
      S_IF: begin
        signal = 16'h0009;
        nxt    = mem_ready ? S_ID : S_IF;
      end
      S_ID: begin
        signal = 16'h0820;
        if (opcode == 4'd15) begin
          case (func)
            6'd29:                         nxt = S_HALT;
            6'd25, 6'd26:                  nxt = S_JR;
            6'd0, 6'd1, 6'd2, 6'd3,
            6'd4, 6'd5, 6'd6, 6'd7, 6'd28: nxt = S_EX;
            default:                       nxt = unknown_dest;
          endcase
        end else begin
          case (opcode)
            4'd0, 4'd1, 4'd2, 4'd3: nxt = S_BR1;
            4'd4, 4'd5, 4'd6:       nxt = S_EX;
            4'd7, 4'd8:             nxt = S_MADR;
            4'd9:                   nxt = S_JMP;
            4'd10:                  nxt = S_JAL;
            default:                nxt = unknown_dest;
          endcase
        end
      end
      S_EX: begin
        if (opcode == 4'd15)     signal = 16'h2400;
        else if (opcode == 4'd5) signal = 16'h3C00;
        else                     signal = 16'h3400;
        nxt = S_WB;
      end
      S_WB: begin
        // WWD only drives the output port, so no register write-back
        if (opcode == 4'd15) signal = (func == 6'd28) ? 16'h0000 : 16'h0280;
        else                 signal = 16'h0200;
        nxt = S_IF;
      end
      S_MADR: begin
        signal = 16'h3400;
        nxt    = S_MEM;
      end
      S_MEM: begin
        signal = (opcode == 4'd7) ? 16'h0018 : 16'h0014;
        if (!mem_ready)          nxt = S_MEM;
        else if (opcode == 4'd7) nxt = S_MWB;
        else                     nxt = S_IF;
      end
      S_MWB: begin
        signal = 16'h0202;
        nxt    = S_IF;
      end
      S_BR1: begin
        signal = 16'h1000;
        nxt    = S_BR2;
      end
      S_BR2: begin
        signal = 16'h4440;
        nxt    = S_IF;
      end
      S_JMP: begin
        signal = 16'h8020;
        nxt    = S_IF;
      end
      S_JAL: begin
        signal = 16'h8320;
        nxt    = S_IF;
      end
      S_JR: begin
        signal = (func == 6'd26) ? 16'hC320 : 16'hC020;
        nxt    = S_IF;
      end
      S_HALT: begin
        signal = 16'h0000;
        nxt    = S_HALT;
      end
      default: begin
        signal = 16'h0000;
        nxt    = S_HALT;
      end
    endcase
  end

  // An instruction retires when control returns to IF or enters HALT
  assign retire = ((nxt == S_IF) && (cur != S_IF)) || ((nxt == S_HALT) && (cur != S_HALT));

  assign state  = cur;
  assign halted = (cur == S_HALT);

endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench: two DUTs (halt / retire-as-NOP on unknown) share stimulus; the driver
// pushes per-cycle expectations from an instruction-level model, a negedge monitor compares.
module tb_mc_control_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  opcode = '0;
  logic [5:0]  func = '0;
  logic        mem_ready = 1'b0;
  logic [15:0] sig_a, sig_b, cnt_a, cnt_b;
  logic [3:0]  st_a, st_b;
  logic        h_a, h_b;

  always #5 clk = ~clk;

  mc_control_unit #(.WORD_SIZE(16), .HALT_ON_UNKNOWN(1'b1)) u_a (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .func(func), .mem_ready(mem_ready),
    .signal(sig_a), .state(st_a), .num_inst(cnt_a), .halted(h_a));

  mc_control_unit #(.WORD_SIZE(16), .HALT_ON_UNKNOWN(1'b0)) u_b (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .func(func), .mem_ready(mem_ready),
    .signal(sig_b), .state(st_b), .num_inst(cnt_b), .halted(h_b));

  typedef struct {
    logic [3:0]  st_a, st_b;
    logic [15:0] sig_a, sig_b;
    logic [15:0] cnt;
    logic        h_a, h_b;
  } exp_t;

  typedef enum {C_ALU, C_WWD, C_ADI, C_ORI, C_LWD, C_SWD, C_BR, C_JMP, C_JAL,
                C_JPR, C_JRL, C_HLT, C_BAD} cls_t;

  exp_t        expq[$];
  logic [15:0] m_cnt = '0;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      chk("state_a",    32'(st_a),  32'(e.st_a));
      chk("signal_a",   32'(sig_a), 32'(e.sig_a));
      chk("num_inst_a", 32'(cnt_a), 32'(e.cnt));
      chk("halted_a",   32'(h_a),   32'(e.h_a));
      chk("state_b",    32'(st_b),  32'(e.st_b));
      chk("signal_b",   32'(sig_b), 32'(e.sig_b));
      chk("num_inst_b", 32'(cnt_b), 32'(e.cnt));
      chk("halted_b",   32'(h_b),   32'(e.h_b));
    end
  end

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic cls_t classify(input logic [3:0] op, input logic [5:0] fn);
    if (op == 4'd15) begin
      if (fn <= 6'd7)  return C_ALU;
      if (fn == 6'd28) return C_WWD;
      if (fn == 6'd29) return C_HLT;
      if (fn == 6'd25) return C_JPR;
      if (fn == 6'd26) return C_JRL;
      return C_BAD;
    end
    if (op <= 4'd3)                return C_BR;
    if (op == 4'd4 || op == 4'd6) return C_ADI;
    if (op == 4'd5)                return C_ORI;
    if (op == 4'd7)                return C_LWD;
    if (op == 4'd8)                return C_SWD;
    if (op == 4'd9)                return C_JMP;
    if (op == 4'd10)               return C_JAL;
    return C_BAD;
  endfunction

  // One clock of stimulus; the expectation describes the DUT state during this cycle
  task automatic step2(input logic [3:0] sa, input logic [15:0] ga, input logic ha,
                       input logic [3:0] sb, input logic [15:0] gb, input logic hb,
                       input logic mr);
    exp_t e;
    mem_ready = mr;
    e.st_a = sa; e.sig_a = ga; e.h_a = ha;
    e.st_b = sb; e.sig_b = gb; e.h_b = hb;
    e.cnt  = m_cnt;
    expq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [3:0] st, input logic [15:0] sg, input logic mr);
    step2(st, sg, st == 4'd15, st, sg, st == 4'd15, mr);
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    mem_ready = rnd();
    opcode    = 4'($urandom_range(0, 15));
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    m_cnt   = '0;
  endtask

  task automatic mem_phase(input logic [15:0] sg, input int stalls, input bit abort);
    step(4'd4, 16'h3400, rnd());
    if (abort) begin
      reset_n = 1'b0;
      step(4'd5, sg, 1'b0);
      reset_n = 1'b1;
      m_cnt   = '0;
      return;
    end
    repeat (stalls) step(4'd5, sg, 1'b0);
    step(4'd5, sg, 1'b1);
  endtask

  // Returns 1 when the instruction leaves a DUT needing reset (HALT or diverged paths)
  task automatic run_inst(input logic [3:0] op, input logic [5:0] fn, input int if_stalls,
                          input int mem_stalls, input bit abort, output bit need_reset);
    cls_t c;
    c          = classify(op, fn);
    need_reset = 1'b0;
    opcode     = op;
    func       = fn;
    repeat (if_stalls) step(4'd0, 16'h0009, 1'b0);
    step(4'd0, 16'h0009, 1'b1);
    step(4'd1, 16'h0820, rnd());
    case (c)
      C_ALU: begin step(4'd2, 16'h2400, rnd()); step(4'd3, 16'h0280, rnd()); end
      C_WWD: begin step(4'd2, 16'h2400, rnd()); step(4'd3, 16'h0000, rnd()); end
      C_ADI: begin step(4'd2, 16'h3400, rnd()); step(4'd3, 16'h0200, rnd()); end
      C_ORI: begin step(4'd2, 16'h3C00, rnd()); step(4'd3, 16'h0200, rnd()); end
      C_LWD: begin
        mem_phase(16'h0018, mem_stalls, abort);
        if (abort) return;
        step(4'd6, 16'h0202, rnd());
      end
      C_SWD: begin
        mem_phase(16'h0014, mem_stalls, abort);
        if (abort) return;
      end
      C_BR:  begin step(4'd7, 16'h1000, rnd()); step(4'd8, 16'h4440, rnd()); end
      C_JMP: step(4'd9,  16'h8020, rnd());
      C_JAL: step(4'd10, 16'h8320, rnd());
      C_JPR: step(4'd11, 16'hC020, rnd());
      C_JRL: step(4'd11, 16'hC320, rnd());
      C_HLT: begin
        m_cnt++;
        for (int i = 0; i < 10; i++) step(4'd15, 16'h0000, 1'(i % 2));
        need_reset = 1'b1;
        return;
      end
      default: begin
        m_cnt++;
        step2(4'd15, 16'h0000, 1'b1, 4'd0, 16'h0009, 1'b0, rnd());
        need_reset = 1'b1;
        return;
      end
    endcase
    m_cnt++;
  endtask

  task automatic pick_valid(output logic [3:0] op, output logic [5:0] fn);
    fn = 6'($urandom_range(0, 63));
    case ($urandom_range(0, 9))
      0: begin op = 4'd15; fn = 6'($urandom_range(0, 7)); end
      1: begin op = 4'd15; fn = 6'd28; end
      2: op = 4'($urandom_range(4, 6));
      3: op = 4'd7;
      4: op = 4'd8;
      5: op = 4'($urandom_range(0, 3));
      6: op = 4'd9;
      7: op = 4'd10;
      8: begin op = 4'd15; fn = 6'd25; end
      default: begin op = 4'd15; fn = 6'd26; end
    endcase
  endtask

  initial begin
    bit          nr;
    logic [3:0]  op;
    logic [5:0]  fn;
    do_reset();
    run_inst(4'd15, 6'd0,  0, 0, 0, nr);
    run_inst(4'd7,  6'd3,  2, 2, 0, nr);
    run_inst(4'd1,  6'd0,  0, 0, 0, nr);
    run_inst(4'd8,  6'd0,  0, 1, 0, nr);
    run_inst(4'd15, 6'd26, 0, 0, 0, nr);
    run_inst(4'd15, 6'd29, 1, 0, 0, nr);
    do_reset();
    run_inst(4'd11, 6'd0,  0, 0, 0, nr);
    do_reset();
    run_inst(4'd15, 6'd26, 0, 0, 0, nr);
    run_inst(4'd7,  6'd0,  0, 0, 1, nr);
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 19))
        0: begin op = 4'd15; fn = 6'd29; end
        1: begin
          if (rnd()) begin op = 4'($urandom_range(11, 14)); fn = 6'($urandom_range(0, 63)); end
          else       begin op = 4'd15; fn = 6'($urandom_range(8, 24)); end
        end
        default: pick_valid(op, fn);
      endcase
      run_inst(op, fn, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 24) == 0, nr);
      if (nr) do_reset();
    end
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(expq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
